// File: rtl/sdr_pkg.sv
// sdr_pkg: shared types, constants and helpers for the SDR receive chain
//   sync_state_e : HUNT / CHECK / LOCK frame-sync flywheel states
//   CCSDS_ASM    : CCSDS attached sync marker
//   cnt_width(n) : bits needed to hold the values 0..n (at least 1)
package sdr_pkg;

    typedef enum logic [1:0] {HUNT, CHECK, LOCK} sync_state_e;

    localparam logic [31:0] CCSDS_ASM = 32'h1ACF_FC1D;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_correlator.sv
// sync_correlator: tests the marker at every bit alignment of the newest word
//   c_i       : {history, newest word}, newest bit at c_i[0]
//   hit_o     : hit_o[k] set when c_i[k +: SL] is within MAX_ERRS bits of SYNC_WORD
//   inv_hit_o : same against ~SYNC_WORD (only with FRAME_SYNC_INVERT_EN)
module sync_correlator
    import sdr_pkg::*;
#(
    parameter int             WS        = 8,
    parameter int             SL        = 32,
    parameter logic [SL-1:0]  SYNC_WORD = SL'(CCSDS_ASM),
    parameter int             MAX_ERRS  = 0
) (
    input  logic [SL+WS-2:0] c_i,
`ifdef FRAME_SYNC_INVERT_EN
    output logic [WS-1:0]    inv_hit_o,
`endif
    output logic [WS-1:0]    hit_o
);

    localparam int            CW = cnt_width(SL);
    localparam logic [CW-1:0] ME = CW'(MAX_ERRS);

    for (genvar k = 0; k < WS; k++) begin : g_cand
        logic [CW-1:0] errs;
        assign errs     = CW'($countones(c_i[k +: SL] ^ SYNC_WORD));
        assign hit_o[k] = errs <= ME;
`ifdef FRAME_SYNC_INVERT_EN
        // mismatches against ~SYNC_WORD are the matches against SYNC_WORD
        assign inv_hit_o[k] = (CW'(SL) - errs) <= ME;
`endif
    end

endmodule

// File: rtl/frame_sync.sv
// frame_sync: attached-sync-marker search, hunt/check/lock flywheel, payload re-alignment
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_ce, i_word     : one descrambled WS-bit word per i_ce, bit WS-1 first in time
//   o_valid, o_word  : one-cycle pulse with a frame-aligned payload word (o_word holds)
//   o_sof            : with o_valid, first payload word of a frame
//   o_locked         : flywheel is in LOCK
//   o_inverted       : latched marker polarity
// FRAME_SYNC_INVERT_EN: also search for the inverted marker and invert payload to match;
// without it o_inverted is tied 0.
module frame_sync
    import sdr_pkg::*;
#(
    parameter int             WS         = 8,
    parameter int             SL         = 32,
    parameter logic [SL-1:0]  SYNC_WORD  = SL'(CCSDS_ASM),
    parameter int             PW         = 128,
    parameter int             MAX_ERRS   = 0,
    parameter int             CONFIRM    = 1,
    parameter int             MISS_LIMIT = 3
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic [WS-1:0] i_word,
    output logic          o_valid,
    output logic [WS-1:0] o_word,
    output logic          o_sof,
    output logic          o_locked,
    output logic          o_inverted
);

    localparam int FW  = SL / WS + PW;
    localparam int PSW = cnt_width(FW - 1);
    localparam int HW  = cnt_width(CONFIRM);
    localparam int MW  = cnt_width(MISS_LIMIT);
    localparam int AW  = cnt_width(WS - 1);
    localparam logic [PSW-1:0] POS_LAST  = PSW'(FW - 1);
    localparam logic [PSW-1:0] POS_PW    = PSW'(PW);
    localparam logic [HW-1:0]  HITS_LOCK = HW'(CONFIRM);
    localparam logic [MW-1:0]  MISS_DROP = MW'(MISS_LIMIT);

    sync_state_e    state_q;
    logic [SL-2:0]  hist_q;
    logic [AW-1:0]  align_q;
    logic [PSW-1:0] pos_q;
    logic [HW-1:0]  hits_q;
    logic [MW-1:0]  misses_q;
    logic           valid_q;
    logic           sof_q;
    logic           locked_q;
    logic [WS-1:0]  word_q;

    logic [SL+WS-2:0] c;
    logic [WS-1:0]    hit;
    logic             found;
    logic [AW-1:0]    k_sel;
    logic             trk_hit;
    logic [WS-1:0]    payload;
    logic [PSW-1:0]   pos_d;

    assign c     = {hist_q, i_word};
    assign pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;

`ifdef FRAME_SYNC_INVERT_EN
    logic [WS-1:0] inv_hit;
    logic          pol_q;
    logic          pol_sel;

    sync_correlator #(.WS(WS), .SL(SL), .SYNC_WORD(SYNC_WORD), .MAX_ERRS(MAX_ERRS)) u_corr (
        .c_i       (c),
        .inv_hit_o (inv_hit),
        .hit_o     (hit)
    );

    assign trk_hit    = pol_q ? inv_hit[align_q] : hit[align_q];
    assign payload    = c[align_q +: WS] ^ {WS{pol_q}};
    assign o_inverted = pol_q;

    // scanning downwards lets the lowest k win, and true polarity beats inverted at equal k
    always_comb begin
        found   = |{hit, inv_hit};
        k_sel   = '0;
        pol_sel = 1'b0;
        for (int k = WS - 1; k >= 0; k--) begin
            if (inv_hit[k]) begin
                k_sel   = AW'(k);
                pol_sel = 1'b1;
            end
            if (hit[k]) begin
                k_sel   = AW'(k);
                pol_sel = 1'b0;
            end
        end
    end
`else
    sync_correlator #(.WS(WS), .SL(SL), .SYNC_WORD(SYNC_WORD), .MAX_ERRS(MAX_ERRS)) u_corr (
        .c_i   (c),
        .hit_o (hit)
    );

    assign trk_hit    = hit[align_q];
    assign payload    = c[align_q +: WS];
    assign o_inverted = 1'b0;

    always_comb begin
        found = |hit;
        k_sel = '0;
        for (int k = WS - 1; k >= 0; k--) k_sel = hit[k] ? AW'(k) : k_sel;
    end
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= HUNT;
            hist_q   <= '0;
            align_q  <= '0;
            pos_q    <= '0;
            hits_q   <= '0;
            misses_q <= '0;
            valid_q  <= 1'b0;
            sof_q    <= 1'b0;
            locked_q <= 1'b0;
            word_q   <= '0;
`ifdef FRAME_SYNC_INVERT_EN
            pol_q    <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            if (i_ce) begin
                hist_q <= c[SL-2:0];
                case (state_q)
                    HUNT: begin
                        if (found) begin
                            state_q <= CHECK;
                            align_q <= k_sel;
                            pos_q   <= PSW'(1);
                            hits_q  <= '0;
`ifdef FRAME_SYNC_INVERT_EN
                            pol_q   <= pol_sel;
`endif
                        end
                    end
                    CHECK: begin
                        pos_q <= pos_d;
                        if (pos_q == '0) begin
                            if (!trk_hit) begin
                                state_q <= HUNT;
                            end else if (hits_q + 1'b1 == HITS_LOCK) begin
                                state_q  <= LOCK;
                                misses_q <= '0;
                                locked_q <= 1'b1;
                            end else begin
                                hits_q <= hits_q + 1'b1;
                            end
                        end
                    end
                    LOCK: begin
                        pos_q <= pos_d;
                        // payload keeps flowing through a missed marker (flywheel)
                        if (pos_q != '0 && pos_q <= POS_PW) begin
                            valid_q <= 1'b1;
                            sof_q   <= pos_q == PSW'(1);
                            word_q  <= payload;
                        end
                        if (pos_q == '0) begin
                            if (trk_hit) begin
                                misses_q <= '0;
                            end else if (misses_q + 1'b1 == MISS_DROP) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                            end else begin
                                misses_q <= misses_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign o_valid  = valid_q;
    assign o_sof    = sof_q;
    assign o_locked = locked_q;
    assign o_word   = word_q;

endmodule
